// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run/ack sequencer in front of the 9-bit core.
package run_ctrl_pkg;

    localparam int RUN_CYCLE_W         = 16;
    localparam int RUN_DEFAULT_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } run_state_t;

    // Finished states hold ack until the next start.
    function automatic logic state_is_finished(input run_state_t st);
        return (st == DONE) || (st == TIMEOUT);
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// RUN-cycle counter: synchronous clear wins over enable; tc_o flags count == TIMEOUT-1.
module run_cycle_counter #(
    parameter int CYCLE_W = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               enable_i,
    output logic [CYCLE_W-1:0] count_o,
    output logic               tc_o
);

    localparam logic [CYCLE_W-1:0] TC_VAL = CYCLE_W'(TIMEOUT - 1);
    localparam logic [CYCLE_W-1:0] ONE    = {{(CYCLE_W-1){1'b0}}, 1'b1};

    logic [CYCLE_W-1:0] count_q;
    logic [CYCLE_W-1:0] count_d;

    // Next count; natural overflow wraps modulo 2**CYCLE_W.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CYCLE_W{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CYCLE_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC_VAL);

endmodule

// File: rtl/run_controller.sv
// Start/ack Moore sequencer gating instruction issue for the 9-bit core.
// Watchdog timeout is built only when RUN_CTRL_WATCHDOG_EN is defined.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_W = RUN_CYCLE_W,
    parameter int TIMEOUT = RUN_DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               done,
    output logic               run_en,
    output logic               pc_clear,
    output logic               ack,
    output logic               timed_out,
    output logic [CYCLE_W-1:0] cycle_count
);

    run_state_t state_q;
    run_state_t state_d;
    logic       tc_s;
    logic       wd_hit_s;
    logic       run_en_q;
    logic       pc_clear_q;
    logic       ack_q;
    logic       timed_out_q;

`ifdef RUN_CTRL_WATCHDOG_EN
    assign wd_hit_s = tc_s;
`else
    assign wd_hit_s = tc_s & 1'b0;
`endif

    // Next-state logic; done beats the watchdog on the same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ARMED;
                else       state_d = IDLE;
            end
            ARMED: begin
                if (start) state_d = ARMED;
                else       state_d = RUN;
            end
            RUN: begin
                if (done)          state_d = DONE;
                else if (wd_hit_s) state_d = run_ctrl_pkg::TIMEOUT;
                else               state_d = RUN;
            end
            DONE, run_ctrl_pkg::TIMEOUT: begin
                if (start) state_d = ARMED;
                else       state_d = state_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decoded from the next state into flops so they change with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_en_q    <= 1'b0;
            pc_clear_q  <= 1'b0;
            ack_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            run_en_q    <= (state_d == RUN);
            pc_clear_q  <= (state_d == ARMED);
            ack_q       <= state_is_finished(state_d);
            timed_out_q <= (state_d == run_ctrl_pkg::TIMEOUT);
        end
    end

    run_cycle_counter #(
        .CYCLE_W (CYCLE_W),
        .TIMEOUT (TIMEOUT)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_d == ARMED),
        .enable_i (state_q == RUN),
        .count_o  (cycle_count),
        .tc_o     (tc_s)
    );

    assign run_en    = run_en_q;
    assign pc_clear  = pc_clear_q;
    assign ack       = ack_q;
    assign timed_out = timed_out_q;

endmodule
